// File: rtl/mem_port_arbiter.sv
// Shares one variable-latency memory port between instruction fetch and load/store.
// Define ARB_ROUND_ROBIN_EN for round-robin tie-breaking; fixed data-first priority otherwise.
module mem_port_arbiter #(
    parameter int unsigned AW      = 32,
    parameter int unsigned DW      = 32,
    parameter int unsigned TIMEOUT = 15
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          if_req_i,
    input  logic [AW-1:0] if_addr_i,
    output logic          if_ack_o,
    output logic [DW-1:0] if_rdata_o,
    input  logic          d_req_i,
    input  logic          d_we_i,
    input  logic [AW-1:0] d_addr_i,
    input  logic [DW-1:0] d_wdata_i,
    output logic          d_ack_o,
    output logic [DW-1:0] d_rdata_o,
    output logic [AW-1:0] mem_addr_o,
    output logic [DW-1:0] mem_wdata_o,
    output logic          mem_rd_o,
    output logic          mem_wr_o,
    input  logic [DW-1:0] mem_rdata_i,
    input  logic          mem_ready_i,
    output logic          stall_o,
    output logic          err_o,
    input  logic          err_clr_i
);

    localparam int unsigned   CW      = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] CntLast = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {StIdle, StBusy, StResp} state_e;

    state_e        state_q;
    logic          owner_q;  // 1 = data port owns the access
    logic          we_q;
    logic [CW-1:0] cnt_q;
    logic [AW-1:0] mem_addr_q;
    logic [DW-1:0] mem_wdata_q;
    logic          mem_rd_q;
    logic          mem_wr_q;
    logic [DW-1:0] if_rdata_q;
    logic [DW-1:0] d_rdata_q;
    logic          if_ack_q;
    logic          d_ack_q;
    logic          err_q;
    logic          grant_data;
    logic          both_req;

    assign both_req = if_req_i & d_req_i;

`ifdef ARB_ROUND_ROBIN_EN
    logic rr_q;  // 1 = data wins the next tie

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rr_q <= 1'b1;
        end else if (state_q == StIdle && both_req) begin
            rr_q <= ~grant_data;
        end
    end

    assign grant_data = both_req ? rr_q : d_req_i;
`else
    assign grant_data = d_req_i;
`endif

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= StIdle;
            owner_q     <= 1'b0;
            we_q        <= 1'b0;
            cnt_q       <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_rd_q    <= 1'b0;
            mem_wr_q    <= 1'b0;
            if_rdata_q  <= '0;
            d_rdata_q   <= '0;
            if_ack_q    <= 1'b0;
            d_ack_q     <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            // A timeout set below overrides this clear on the same edge.
            if (err_clr_i) err_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (if_req_i || d_req_i) begin
                        owner_q     <= grant_data;
                        we_q        <= grant_data & d_we_i;
                        mem_addr_q  <= grant_data ? d_addr_i : if_addr_i;
                        mem_wdata_q <= grant_data ? d_wdata_i : '0;
                        mem_rd_q    <= ~(grant_data & d_we_i);
                        mem_wr_q    <= grant_data & d_we_i;
                        cnt_q       <= '0;
                        state_q     <= StBusy;
                    end
                end
                StBusy: begin
                    if (mem_ready_i) begin
                        if (!we_q) begin
                            if (owner_q) d_rdata_q <= mem_rdata_i;
                            else         if_rdata_q <= mem_rdata_i;
                        end
                        mem_rd_q <= 1'b0;
                        mem_wr_q <= 1'b0;
                        if_ack_q <= ~owner_q;
                        d_ack_q  <= owner_q;
                        state_q  <= StResp;
                    end else if (cnt_q == CntLast) begin
                        if (owner_q) d_rdata_q <= '1;
                        else         if_rdata_q <= '1;
                        mem_rd_q <= 1'b0;
                        mem_wr_q <= 1'b0;
                        err_q    <= 1'b1;
                        cnt_q    <= cnt_q + 1'b1;
                        if_ack_q <= ~owner_q;
                        d_ack_q  <= owner_q;
                        state_q  <= StResp;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                StResp: begin
                    if_ack_q <= 1'b0;
                    d_ack_q  <= 1'b0;
                    state_q  <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign if_ack_o    = if_ack_q;
    assign d_ack_o     = d_ack_q;
    assign if_rdata_o  = if_rdata_q;
    assign d_rdata_o   = d_rdata_q;
    assign mem_addr_o  = mem_addr_q;
    assign mem_wdata_o = mem_wdata_q;
    assign mem_rd_o    = mem_rd_q;
    assign mem_wr_o    = mem_wr_q;
    assign err_o       = err_q;
    assign stall_o     = (if_req_i & ~if_ack_q) | (d_req_i & ~d_ack_q);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: vector table of single accesses plus
// hand-written arbitration, timeout/err_clr and mid-access reset sequences.
module tb_mem_port_arbiter;

    localparam int TIMEOUT = 15;
    localparam logic [31:0] Junk = 32'h0BAD0BAD;
    localparam logic [31:0] Key  = 32'h5A5A0000;

    logic        clk, rst;
    logic        if_req, if_ack, d_req, d_we, d_ack;
    logic [31:0] if_addr, if_rdata, d_addr, d_wdata, d_rdata;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_rd, mem_wr, mem_ready, stall, err, err_clr;

    int checks = 0;
    int failures = 0;

    mem_port_arbiter #(.AW(32), .DW(32), .TIMEOUT(TIMEOUT)) dut (
        .clk_i(clk), .rst_i(rst),
        .if_req_i(if_req), .if_addr_i(if_addr), .if_ack_o(if_ack), .if_rdata_o(if_rdata),
        .d_req_i(d_req), .d_we_i(d_we), .d_addr_i(d_addr), .d_wdata_i(d_wdata),
        .d_ack_o(d_ack), .d_rdata_o(d_rdata),
        .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata), .mem_rd_o(mem_rd), .mem_wr_o(mem_wr),
        .mem_rdata_i(mem_rdata), .mem_ready_i(mem_ready),
        .stall_o(stall), .err_o(err), .err_clr_i(err_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running, required finish");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    // delay = cycle (after the request cycle) in which mem_ready pulses; 0 = never
    task automatic do_access(input string name, input bit is_d, input bit we,
                             input logic [31:0] addr, input logic [31:0] wdata, input int delay,
                             input logic [31:0] rdata, input logic [31:0] exp_rdata,
                             input int exp_lat, input int clr_cycle);
        int   ack_cyc = -1;
        int   last_cmd;
        bit   cmd_bad = 0, stall_bad = 0, other_bad = 0, exp_cmd;
        logic own_ack;
        logic [31:0] got = '0;
        last_cmd = (delay > 0) ? delay : TIMEOUT;
        if (is_d) begin
            d_req = 1; d_we = we; d_addr = addr; d_wdata = wdata;
        end else begin
            if_req = 1; if_addr = addr;
        end
        mem_ready = 1; mem_rdata = Junk;  // ready in IDLE must be ignored
        #1;
        if (stall !== 1'b1) stall_bad = 1;
        for (int c = 1; c <= TIMEOUT + 3 && ack_cyc < 0; c++) begin
            @(posedge clk); #1;
            mem_ready = (c == delay) || (c > last_cmd);
            mem_rdata = (c == delay) ? rdata : Junk;
            err_clr   = (c == clr_cycle);
            #1;
            exp_cmd = (c <= last_cmd);
            if (mem_rd !== (exp_cmd & ~we) || mem_wr !== (exp_cmd & we)) cmd_bad = 1;
            if (exp_cmd && (mem_addr !== addr || (we && mem_wdata !== wdata))) cmd_bad = 1;
            own_ack = is_d ? d_ack : if_ack;
            if ((is_d ? if_ack : d_ack) !== 1'b0) other_bad = 1;
            if (own_ack === 1'b1) begin
                ack_cyc = c;
                got = is_d ? d_rdata : if_rdata;
                if (stall !== 1'b0) stall_bad = 1;
                if (is_d) d_req = 0; else if_req = 0;
            end else if (stall !== 1'b1) begin
                stall_bad = 1;
            end
        end
        err_clr = 0;
        if (is_d) d_req = 0; else if_req = 0;
        check({name, "_latency"}, ack_cyc, exp_lat);
        check({name, "_rdata"}, got, exp_rdata);
        check({name, "_cmd"}, {31'd0, cmd_bad}, 32'd0);
        check({name, "_stall"}, {31'd0, stall_bad}, 32'd0);
        check({name, "_other_ack"}, {31'd0, other_bad}, 32'd0);
        @(posedge clk); #1;
        mem_ready = 0;
        check({name, "_ack_pulse"}, {30'd0, if_ack, d_ack}, 32'd0);
        check({name, "_rdata_held"}, is_d ? d_rdata : if_rdata, exp_rdata);
    endtask

    typedef struct {
        bit          is_d;
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          delay;
        logic [31:0] rdata;
        logic [31:0] exp_rdata;
        int          exp_lat;
    } vec_t;

    vec_t vecs[6];
    bit   exp_order[4];
    bit   got_order[4];

    initial begin
        vecs[0] = '{0, 0, 32'h40,  32'h0,        1,  32'h8C220004, 32'h8C220004, 2};
        vecs[1] = '{1, 1, 32'h100, 32'hCAFEF00D, 3,  32'h11111111, 32'h00000000, 4};
        vecs[2] = '{1, 0, 32'h104, 32'h0,        2,  32'h12345678, 32'h12345678, 3};
        vecs[3] = '{1, 1, 32'h108, 32'h0000A5A5, 1,  32'h22222222, 32'h12345678, 2};
        vecs[4] = '{0, 0, 32'h44,  32'h0,        5,  32'hDEADBEEF, 32'hDEADBEEF, 6};
        vecs[5] = '{1, 0, 32'h200, 32'h0,        15, 32'h0BADF00D, 32'h0BADF00D, 16};
`ifdef ARB_ROUND_ROBIN_EN
        exp_order = '{1, 0, 0, 1};
`else
        exp_order = '{1, 0, 1, 0};
`endif

        rst = 1; if_req = 0; if_addr = 0; d_req = 0; d_we = 0; d_addr = 0; d_wdata = 0;
        mem_rdata = 0; mem_ready = 0; err_clr = 0;
        #12;
        check("reset_cmd", {30'd0, mem_rd, mem_wr}, 32'd0);
        check("reset_acks", {30'd0, if_ack, d_ack}, 32'd0);
        check("reset_addr", mem_addr, 32'd0);
        check("reset_wdata", mem_wdata, 32'd0);
        check("reset_rdata", if_rdata | d_rdata, 32'd0);
        check("reset_err_stall", {30'd0, err, stall}, 32'd0);
        @(posedge clk); #1;
        rst = 0;
        @(posedge clk); #1;

        for (int i = 0; i < 6; i++) begin
            do_access($sformatf("vec%0d", i), vecs[i].is_d, vecs[i].we, vecs[i].addr,
                      vecs[i].wdata, vecs[i].delay, vecs[i].rdata, vecs[i].exp_rdata,
                      vecs[i].exp_lat, 0);
        end
        check("no_err_at_limit", {31'd0, err}, 32'd0);

        begin : arb_seq
            int  round = 1, n = 0, overlap = 0;
            bit  done = 0;
            if_req = 1; if_addr = 32'h50; d_req = 1; d_we = 0; d_addr = 32'h60;
            for (int c = 0; c < 60 && !done; c++) begin
                @(posedge clk); #1;
                if (if_ack && d_ack) overlap++;
                if (d_ack) begin
                    if (n < 4) got_order[n] = 1;
                    n++;
                    d_req = 0;
                    check("arb_d_rdata", d_rdata, 32'h60 ^ Key);
                end
                if (if_ack) begin
                    if (n < 4) got_order[n] = 0;
                    n++;
                    if_req = 0;
                    check("arb_if_rdata", if_rdata, 32'h50 ^ Key);
                end
                if (!if_req && !d_req) begin
                    if (round == 1) begin
                        if_req = 1; d_req = 1; round = 2;
                    end else begin
                        done = 1;
                    end
                end
                mem_ready = mem_rd | mem_wr;
                mem_rdata = mem_addr ^ Key;
            end
            mem_ready = 0;
            check("arb_done", {31'd0, done}, 32'd1);
            check("arb_count", n, 4);
            check("arb_overlap", overlap, 0);
            for (int k = 0; k < 4; k++)
                check($sformatf("arb_order%0d", k), {31'd0, got_order[k]}, {31'd0, exp_order[k]});
            @(posedge clk); #1;
        end

        do_access("timeout_load", 1, 0, 32'h300, 32'h0, 0, 32'h0, 32'hFFFFFFFF, TIMEOUT + 1, 0);
        check("timeout_err", {31'd0, err}, 32'd1);
        err_clr = 1;
        @(posedge clk); #1;
        err_clr = 0;
        check("err_clr", {31'd0, err}, 32'd0);
        do_access("timeout_clr", 0, 0, 32'h304, 32'h0, 0, 32'h0, 32'hFFFFFFFF, TIMEOUT + 1,
                  TIMEOUT);
        check("err_set_wins", {31'd0, err}, 32'd1);
        err_clr = 1;
        @(posedge clk); #1;
        err_clr = 0;
        check("err_clr2", {31'd0, err}, 32'd0);

        if_req = 1; if_addr = 32'h80; mem_ready = 0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("rst_pre_rd", {31'd0, mem_rd}, 32'd1);
        #2;
        rst = 1;
        #1;
        check("rst_rd_drop", {31'd0, mem_rd}, 32'd0);
        check("rst_no_ack", {30'd0, if_ack, d_ack}, 32'd0);
        check("rst_rdata", if_rdata | d_rdata, 32'd0);
        if_req = 0;
        @(posedge clk); #1;
        rst = 0;
        check("rst_still_idle", {29'd0, mem_rd, if_ack, d_ack}, 32'd0);
        @(posedge clk); #1;
        do_access("post_rst_fetch", 0, 0, 32'h84, 32'h0, 1, 32'h13572468, 32'h13572468, 2, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares one single-ported, variable-latency memory between the processor's instruction-fetch path and its load/store path. Each requester uses a req/ack handshake, and the block drives a `stall` line that the top level uses to gate `pc_enable`. A per-access watchdog makes sure a memory that never answers still completes the handshake and raises a sticky error flag.

## Interface
- `AW`, 32: address width.
- `DW`, 32: data width.
- `TIMEOUT`, 15: maximum wait cycles per access before abort; must be ≥1. Counter width is `$clog2(TIMEOUT+1)`.

- `clk` in 1: single clock; all state updates on its rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `if_req` in 1: instruction fetch request.
- `if_addr` in AW: fetch address.
- `if_ack` out 1: one-cycle completion pulse for fetch.
- `if_rdata` out DW: fetched word; valid while `if_ack`=1 and held until the next fetch completes.
- `d_req` in 1: data access request.
- `d_we` in 1: 1 = store, 0 = load.
- `d_addr` in AW: data address.
- `d_wdata` in DW: store data.
- `d_ack` out 1: one-cycle completion pulse for data.
- `d_rdata` out DW: load result; valid while `d_ack`=1 and held until the next data completion.
- `mem_addr` out AW, `mem_wdata` out DW, `mem_rd` out 1, `mem_wr` out 1: memory command, registered.
- `mem_rdata` in DW, `mem_ready` in 1: memory response.
- `stall` out 1: combinational, `(if_req & ~if_ack) | (d_req & ~d_ack)`.
- `err` out 1: sticky timeout flag.
- `err_clr` in 1: clears `err`.

## Operation
- FSM states are IDLE, BUSY and RESP.
- **IDLE**
  - If any request is high, grant one and latch its address, write data and `we`, plus a grant-owner bit.
  - Move to BUSY and clear the wait counter.
- **BUSY**
  - Hold `mem_addr` and `mem_wdata`.
  - `mem_rd` = ~we and `mem_wr` = we of the owner; exactly one of them is high.
  - When `mem_ready`=1:
    - For a load or fetch, capture `mem_rdata` into the owner's rdata register.
    - Drop `mem_rd`/`mem_wr` and move to RESP.
  - Otherwise, increment the wait counter.
  - When the counter reaches `TIMEOUT` with `mem_ready` still 0:
    - Drop the command, set `err`, and load the owner's rdata with all-ones.
    - Move to RESP.
- **RESP**
  - Pulse the owner's ack for this single cycle, then return to IDLE.
- A store completes with `d_ack`, and `d_rdata` keeps its previous value.
- Requesters hold their request fields stable from `req` until `ack`. The block samples the fields only in IDLE.
- Deasserting `req` before `ack` is illegal, and the block's behaviour is then undefined.
- `err_clr` has priority below a simultaneous timeout set: the flag stays 1.
- **Reset values:** state IDLE, all acks 0, `mem_rd`/`mem_wr` 0, `mem_addr`/`mem_wdata`/`if_rdata`/`d_rdata` 0, `err` 0, counter 0, round-robin pointer pointing at data.

## Timing
- Request sampled in IDLE at edge N; the command is visible from cycle N+1.
- `mem_ready` is first honoured in cycle N+1. If ready in cycle N+k, ack is high in cycle N+k+1 and the block is back in IDLE at N+k+2.
- Minimum latency is req-to-ack 2 cycles, 3 cycles per access including the return to IDLE.
- Back-to-back: a requester may keep `req` high after ack to issue a new request, which is sampled in the IDLE cycle.
- A timeout abort asserts ack in cycle N+TIMEOUT+1.
- `mem_ready` outside BUSY is ignored.
- An asynchronous `rst` mid-access drops `mem_rd`/`mem_wr` immediately and abandons the access with no ack.

## Configuration
- `ARB_ROUND_ROBIN_EN` defined:
  - When both requests are pending in IDLE, the grant goes to the port opposite the last winner.
  - The pointer updates only on grants made while both requests were pending.
- `ARB_ROUND_ROBIN_EN` undefined:
  - Fixed priority, data over fetch.
  - No pointer register exists.

## Test plan
- **Single fetch:** `if_req`=1, `if_addr`=0x40, memory returns 0x8C220004 with `mem_ready` in the first BUSY cycle.
  - `mem_rd`=1 only in cycle 1 and `if_ack` in cycle 2 with `if_rdata`=0x8C220004.
  - `stall` is 1 in cycles 0-1 and 0 in cycle 2.
- **Store with wait states:** `d_req`=1, `d_we`=1, `d_addr`=0x100, `d_wdata`=0xCAFEF00D, `mem_ready` after 3 cycles.
  - `mem_wr` high for 3 cycles with correct address and data.
  - `d_ack` one cycle later; `d_rdata` unchanged.
- **Simultaneous requests, repeated twice:**
  - Without the macro, data is served before fetch both times.
  - With `ARB_ROUND_ROBIN_EN`, the order is data, fetch, fetch, data.
  - No ack overlap in any case.
- **Timeout:** load with `mem_ready` held 0 and `TIMEOUT`=15.
  - Command drops after 15 BUSY cycles.
  - `d_ack` with `d_rdata`=0xFFFFFFFF and `err`=1.
  - `err_clr` pulse returns `err` to 0.
- **Reset mid-access:** assert `rst` during BUSY.
  - `mem_rd` falls in the same cycle, with no ack.
  - After release, a new fetch completes normally with 3-cycle latency.
